// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin share of one MDIO controller; MDIO_START 1 cycle after grant, earliest response 3 cycles after request.
// Requesters hold REQ_VALID until REQ_READY; optional MDIO_ARB_OPCODE_CHECK_EN rejects malformed frames without issuing them.
module mdio_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [32*N_REQ-1:0]  REQ_DATA,
    output logic [N_REQ-1:0]     REQ_READY,
    output logic [N_REQ-1:0]     RSP_VALID,
    output logic [15:0]          RSP_DATA,
    output logic                 RSP_ERR,
    output logic                 MDIO_START,
    output logic [31:0]          T_DATA,
    input  logic                 DATA_RDY,
    input  logic [15:0]          RD_DATA,
    output logic                 BUSY
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REJECT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [31:0]       t_data_q, t_data_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       req_frame [N_REQ];
    logic              gnt_found;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     cand;
    logic [31:0]       gnt_frame;
    logic              bad_frame;
    logic [N_REQ-1:0]  idx_onehot;

    for (genvar i = 0; i < N_REQ; i++) begin : g_frame
        assign req_frame[i] = REQ_DATA[32*i +: 32];
    end

    // Search starts one past the last completed grant, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(last_grant_q) + 1 + k) % N_REQ);
            if (!gnt_found && REQ_VALID[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_frame = req_frame[gnt_idx];

`ifdef MDIO_ARB_OPCODE_CHECK_EN
    assign bad_frame = (gnt_frame[31:30] != 2'b01) ||
                       (gnt_frame[29:28] == 2'b00) ||
                       (gnt_frame[29:28] == 2'b11);
`else
    assign bad_frame = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        t_data_d     = t_data_q;
        timer_d      = timer_q;
        rsp_data_d   = '0;
        rsp_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    idx_d    = gnt_idx;
                    t_data_d = gnt_frame;
                    state_d  = bad_frame ? S_REJECT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // DATA_RDY takes precedence over an expiring timer.
                if (DATA_RDY) begin
                    rsp_data_d = (t_data_q[29:28] == 2'b10) ? RD_DATA : 16'h0;
                    state_d    = S_RESP;
                end else if (timer_q >= TW'(TIMEOUT)) begin
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_REJECT: begin
                rsp_err_d = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                last_grant_d = idx_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            last_grant_q <= IW'(N_REQ - 1);
            t_data_q     <= '0;
            timer_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            t_data_q     <= t_data_d;
            timer_q      <= timer_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign idx_onehot = N_REQ'(1) << idx_q;
    assign MDIO_START = (state_q == S_ISSUE);
    assign REQ_READY  = (state_q == S_ISSUE || state_q == S_REJECT) ? idx_onehot : '0;
    assign RSP_VALID  = (state_q == S_RESP) ? idx_onehot : '0;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_ERR    = rsp_err_q;
    assign T_DATA     = t_data_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed-vector bench for mdio_arbiter: single read, fairness, timeout, write, async reset, frame check.
module tb_mdio_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 255;
    localparam int TW      = 8;

    logic                 CLK;
    logic                 RESET;
    logic [N_REQ-1:0]     REQ_VALID;
    logic [32*N_REQ-1:0]  REQ_DATA;
    logic [N_REQ-1:0]     REQ_READY;
    logic [N_REQ-1:0]     RSP_VALID;
    logic [15:0]          RSP_DATA;
    logic                 RSP_ERR;
    logic                 MDIO_START;
    logic [31:0]          T_DATA;
    logic                 DATA_RDY;
    logic [15:0]          RD_DATA;
    logic                 BUSY;

    int n_vec = 0;
    int n_bad = 0;

    mdio_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_DATA   (REQ_DATA),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_DATA   (RSP_DATA),
        .RSP_ERR    (RSP_ERR),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .DATA_RDY   (DATA_RDY),
        .RD_DATA    (RD_DATA),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] frame(input logic [1:0] st, input logic [1:0] op,
                                          input logic [4:0] phy, input logic [4:0] rg,
                                          input logic [15:0] wd);
        return {st, op, phy, rg, 2'b10, wd};
    endfunction

    task automatic present(input int r, input logic [31:0] f);
        REQ_DATA[32*r +: 32] = f;
        REQ_VALID[r] = 1'b1;
    endtask

    // Ends in the accept cycle; the granted requester withdraws its valid.
    task automatic wait_ready(input string tag, input int exp_idx);
        int n;
        n = 0;
        while (REQ_READY == '0 && n < 10) begin
            tick;
            n++;
        end
        chk_eq({tag, "_ready"}, 32'(REQ_READY), 32'(1) << exp_idx);
        REQ_VALID = REQ_VALID & ~REQ_READY;
    endtask

    // Called in the accept cycle; ends in the response cycle.
    task automatic finish_txn(input string tag, input int g, input logic [15:0] rd,
                              input logic [15:0] exp_data, input int lat);
        tick;
        chk_eq({tag, "_ready_1cyc"}, 32'(REQ_READY), 0);
        chk_eq({tag, "_start_1cyc"}, 32'(MDIO_START), 0);
        repeat (lat) tick;
        DATA_RDY = 1'b1;
        RD_DATA  = rd;
        tick;
        DATA_RDY = 1'b0;
        RD_DATA  = 16'h0;
        chk_eq({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'(1) << g);
        chk_eq({tag, "_rsp_data"}, 32'(RSP_DATA), 32'(exp_data));
        chk_eq({tag, "_rsp_err"}, 32'(RSP_ERR), 0);
    endtask

    task automatic do_reset;
        RESET = 1'b0;
        tick;
        tick;
        RESET = 1'b1;
    endtask

    int          fair_order [8] = '{0, 1, 2, 3, 0, 3, 0, 3};
    logic [31:0] f_rd2, f_wr0, f_opc;

    initial begin
        RESET     = 1'b0;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        DATA_RDY  = 1'b0;
        RD_DATA   = 16'h0;
        tick;
        chk_eq("rst_busy", 32'(BUSY), 0);
        chk_eq("rst_ready", 32'(REQ_READY), 0);
        chk_eq("rst_rsp_valid", 32'(RSP_VALID), 0);
        chk_eq("rst_start", 32'(MDIO_START), 0);
        chk_eq("rst_tdata", T_DATA, 0);
        chk_eq("rst_rsp_data", 32'(RSP_DATA), 0);
        chk_eq("rst_rsp_err", 32'(RSP_ERR), 0);
        tick;
        RESET = 1'b1;
        tick;

        // Single read from requester 2: PHY 5, reg 3.
        f_rd2 = frame(2'b01, 2'b10, 5'd5, 5'd3, 16'h0);
        present(2, f_rd2);
        wait_ready("rd", 2);
        chk_eq("rd_start", 32'(MDIO_START), 1);
        chk_eq("rd_tdata", T_DATA, f_rd2);
        chk_eq("rd_busy", 32'(BUSY), 1);
        finish_txn("rd", 2, 16'hBEEF, 16'hBEEF, 39);
        chk_eq("rd_tdata_hold", T_DATA, f_rd2);
        tick;
        chk_eq("rd_rsp_valid_clr", 32'(RSP_VALID), 0);
        chk_eq("rd_rsp_data_clr", 32'(RSP_DATA), 0);
        chk_eq("rd_idle", 32'(BUSY), 0);

        // Fairness: all four requesting, then only 0 and 3.
        do_reset;
        for (int r = 0; r < N_REQ; r++)
            REQ_DATA[32*r +: 32] = frame(2'b01, 2'b10, 5'(r), 5'(r), 16'h0);
        REQ_VALID = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) REQ_VALID = 4'b1001;
            wait_ready($sformatf("fair%0d", i), fair_order[i]);
            finish_txn($sformatf("fair%0d", i), fair_order[i],
                       16'hA000 + 16'(fair_order[i]), 16'hA000 + 16'(fair_order[i]), 0);
            REQ_VALID[fair_order[i]] = 1'b1;
        end
        REQ_VALID = '0;
        tick;
        tick;

        // Timeout: no DATA_RDY, junk on RD_DATA.
        present(1, frame(2'b01, 2'b10, 5'd1, 5'd2, 16'h0));
        wait_ready("to", 1);
        tick;
        RD_DATA = 16'hFFFF;
        repeat (TIMEOUT) tick;
        chk_eq("to_before_valid", 32'(RSP_VALID), 0);
        chk_eq("to_before_busy", 32'(BUSY), 1);
        tick;
        chk_eq("to_rsp_valid", 32'(RSP_VALID), 32'b0010);
        chk_eq("to_rsp_err", 32'(RSP_ERR), 1);
        chk_eq("to_rsp_data", 32'(RSP_DATA), 0);
        RD_DATA = 16'h0;
        tick;
        chk_eq("to_err_clr", 32'(RSP_ERR), 0);

        // DATA_RDY in the very cycle the timer expires.
        present(1, frame(2'b01, 2'b10, 5'd1, 5'd4, 16'h0));
        wait_ready("toe", 1);
        tick;
        repeat (TIMEOUT) tick;
        DATA_RDY = 1'b1;
        RD_DATA  = 16'h5A5A;
        tick;
        DATA_RDY = 1'b0;
        RD_DATA  = 16'h0;
        chk_eq("toe_rsp_valid", 32'(RSP_VALID), 32'b0010);
        chk_eq("toe_rsp_err", 32'(RSP_ERR), 0);
        chk_eq("toe_rsp_data", 32'(RSP_DATA), 32'h5A5A);
        tick;

        // Write from requester 0; DATA_RDY during ISSUE and IDLE is ignored.
        f_wr0 = frame(2'b01, 2'b01, 5'd7, 5'd9, 16'hCAFE);
        present(0, f_wr0);
        wait_ready("wr", 0);
        chk_eq("wr_tdata", T_DATA, f_wr0);
        DATA_RDY = 1'b1;
        RD_DATA  = 16'h1234;
        tick;
        DATA_RDY = 1'b0;
        chk_eq("wr_issue_rdy_ignored", 32'(RSP_VALID), 0);
        chk_eq("wr_wait_busy", 32'(BUSY), 1);
        repeat (3) tick;
        DATA_RDY = 1'b1;
        tick;
        DATA_RDY = 1'b0;
        RD_DATA  = 16'h0;
        chk_eq("wr_rsp_valid", 32'(RSP_VALID), 32'b0001);
        chk_eq("wr_rsp_data", 32'(RSP_DATA), 0);
        chk_eq("wr_rsp_err", 32'(RSP_ERR), 0);
        chk_eq("wr_tdata_hold", T_DATA, f_wr0);
        tick;
        DATA_RDY = 1'b1;
        tick;
        DATA_RDY = 1'b0;
        chk_eq("idle_rdy_ignored_busy", 32'(BUSY), 0);
        chk_eq("idle_rdy_ignored_valid", 32'(RSP_VALID), 0);

        // Asynchronous reset while waiting on the controller.
        present(2, f_rd2);
        wait_ready("ar", 2);
        tick;
        tick;
        #2;
        RESET = 1'b0;
        #1;
        chk_eq("ar_busy", 32'(BUSY), 0);
        chk_eq("ar_start", 32'(MDIO_START), 0);
        chk_eq("ar_rsp_valid", 32'(RSP_VALID), 0);
        chk_eq("ar_ready", 32'(REQ_READY), 0);
        chk_eq("ar_tdata", T_DATA, 0);
        tick;
        tick;
        RESET = 1'b1;
        present(0, frame(2'b01, 2'b10, 5'd0, 5'd1, 16'h0));
        present(1, frame(2'b01, 2'b10, 5'd1, 5'd1, 16'h0));
        wait_ready("ar_prio", 0);
        finish_txn("ar_prio", 0, 16'h0101, 16'h0101, 1);
        wait_ready("ar_req1", 1);
        finish_txn("ar_req1", 1, 16'h1111, 16'h1111, 2);
        tick;

        // Frame with op = 11 from requester 3.
        f_opc = frame(2'b01, 2'b11, 5'd2, 5'd2, 16'h0);
        present(3, f_opc);
        wait_ready("opc", 3);
`ifdef MDIO_ARB_OPCODE_CHECK_EN
        chk_eq("opc_start", 32'(MDIO_START), 0);
        tick;
        chk_eq("opc_rsp_valid", 32'(RSP_VALID), 32'b1000);
        chk_eq("opc_rsp_err", 32'(RSP_ERR), 1);
        chk_eq("opc_rsp_data", 32'(RSP_DATA), 0);
        chk_eq("opc_start_resp", 32'(MDIO_START), 0);
`else
        chk_eq("opc_start", 32'(MDIO_START), 1);
        chk_eq("opc_tdata", T_DATA, f_opc);
        finish_txn("opc", 3, 16'h7777, 16'h0, 0);
`endif
        tick;
        chk_eq("opc_idle", 32'(BUSY), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
